// File: rtl/spi_slave_mem_bridge.sv
// spi_slave_mem_bridge
// Purpose: SPI mode-0 device that turns single-lane frames from an external
// master into 32-bit word accesses on the core memory bus. SCLK, CS and SDI
// are oversampled in clk_i, so clk_i must run at least 4x SCLK.
//   Write frame: CMD(8) ADDR(32) WDATA(32)
//   Read frame : CMD(8) ADDR(32) DUMMY(DUMMY_CYCLES) RDATA(32 on SDO)
// Ports:
//   clk_i, rst_ni            system clock, asynchronous active-low reset
//   spi_sclk/spi_cs/spi_sdi0 SPI inputs from the master (asynchronous)
//   spi_sdo0, spi_mode       serial read data out, lane mode (always single)
//   mem_req_o..mem_be_o      memory request, held until mem_gnt_i
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i  memory grant and read response
//   err_o                    1-cycle pulse: dropped write, bad opcode, late read
module spi_slave_mem_bridge #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DUMMY_CYCLES = 8,
  parameter logic [7:0]  CMD_WRITE    = 8'h02,
  parameter logic [7:0]  CMD_READ     = 8'h0B
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              spi_sclk,
  input  logic              spi_cs,
  input  logic              spi_sdi0,
  output logic              spi_sdo0,
  output logic [1:0]        spi_mode,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_WAIT_CS
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [2:0]         r_sclkSync;
  logic [1:0]         r_csSync;
  logic [1:0]         r_sdiSync;
  logic [5:0]         r_bitCnt;
  logic [31:0]        r_rxShift;
  logic [31:0]        r_txShift;
  logic [ADDR_W-1:0]  r_addrLatch;
  logic               r_isRead;
  logic               r_rdValid;
  logic               r_sdo;
  logic               r_req;
  logic               r_we;
  logic [ADDR_W-1:0]  r_memAddr;
  logic [31:0]        r_wdata;
  logic               r_err;

  logic               w_rise;
  logic               w_fall;
  logic               w_csHigh;
  logic               w_sdi;
  logic [31:0]        w_rxWord;
  logic               w_cmdDone;
  logic               w_badCmd;
  logic               w_addrDone;
  logic               w_wdataDone;
  logic               w_dummyDone;
  logic               w_reqBusy;
  logic               w_rdHit;
  logic               w_haveData;
  logic [31:0]        w_txWord;

  // Two-flop synchronisers; the third SCLK flop exists only for edge detection.
  // CS resets high so a reset never looks like the start of a frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sclkSync <= 3'b000;
      r_csSync   <= 2'b11;
      r_sdiSync  <= 2'b00;
    end else begin
      r_sclkSync <= {r_sclkSync[1:0], spi_sclk};
      r_csSync   <= {r_csSync[0], spi_cs};
      r_sdiSync  <= {r_sdiSync[0], spi_sdi0};
    end
  end

  assign w_rise   = r_sclkSync[1] & ~r_sclkSync[2];
  assign w_fall   = ~r_sclkSync[1] & r_sclkSync[2];
  assign w_csHigh = r_csSync[1];
  assign w_sdi    = r_sdiSync[1];
  assign w_rxWord = {r_rxShift[30:0], w_sdi};

  // A request still waiting for grant blocks a new one; a grant in this very
  // cycle frees the slot.
  assign w_reqBusy  = r_req & ~mem_gnt_i;
  assign w_rdHit    = (r_state == S_DUMMY) & mem_rvalid_i & ~r_rdValid;
  assign w_haveData = r_rdValid | w_rdHit;
  assign w_txWord   = w_rdHit ? mem_rdata_i : r_txShift;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_stateNext;
  end

  // Frame sequencing. Phase ends are flagged on the rising edge carrying the
  // last bit, except DUMMY, which ends on the falling edge that launches the
  // first read-data bit. CS high always aborts back to IDLE.
  always_comb begin
    w_stateNext = r_state;
    w_cmdDone   = 1'b0;
    w_badCmd    = 1'b0;
    w_addrDone  = 1'b0;
    w_wdataDone = 1'b0;
    w_dummyDone = 1'b0;
    if (w_csHigh) begin
      w_stateNext = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_stateNext = S_CMD;
        S_CMD: begin
          if (w_rise && r_bitCnt == 6'd7) begin
            if (w_rxWord[7:0] == CMD_WRITE || w_rxWord[7:0] == CMD_READ) begin
              w_cmdDone   = 1'b1;
              w_stateNext = S_ADDR;
            end else begin
              w_badCmd    = 1'b1;
              w_stateNext = S_WAIT_CS;
            end
          end
        end
        S_ADDR: begin
          if (w_rise && r_bitCnt == 6'd31) begin
            w_addrDone  = 1'b1;
            w_stateNext = r_isRead ? S_DUMMY : S_WDATA;
          end
        end
        S_WDATA: begin
          if (w_rise && r_bitCnt == 6'd31) begin
            w_wdataDone = 1'b1;
            w_stateNext = S_WAIT_CS;
          end
        end
        S_DUMMY: begin
          if (w_fall && r_bitCnt == 6'(DUMMY_CYCLES)) begin
            w_dummyDone = 1'b1;
            w_stateNext = S_RDATA;
          end
        end
        S_RDATA: begin
          if (w_rise && r_bitCnt == 6'd31) w_stateNext = S_WAIT_CS;
        end
        S_WAIT_CS: w_stateNext = S_WAIT_CS;
        default:   w_stateNext = S_IDLE;
      endcase
    end
  end

  // Shift registers, bit counter and memory request. Later assignments in
  // this block take priority: a new issue overrides the retire of the old
  // request in the same cycle, and the dummy-end load overrides a capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bitCnt    <= 6'd0;
      r_rxShift   <= 32'h0;
      r_txShift   <= 32'h0;
      r_addrLatch <= '0;
      r_isRead    <= 1'b0;
      r_rdValid   <= 1'b0;
      r_sdo       <= 1'b0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_memAddr   <= '0;
      r_wdata     <= 32'h0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;

      if (w_stateNext != r_state) r_bitCnt <= 6'd0;
      else if (w_rise)            r_bitCnt <= r_bitCnt + 6'd1;

      if (w_rise && (r_state == S_CMD || r_state == S_ADDR || r_state == S_WDATA))
        r_rxShift <= w_rxWord;

      if (w_cmdDone) r_isRead <= (w_rxWord[7:0] == CMD_READ);
      if (w_badCmd)  r_err    <= 1'b1;

      if (r_req && mem_gnt_i) r_req <= 1'b0;

      if (w_addrDone) begin
        r_addrLatch <= w_rxWord[ADDR_W-1:0];
        if (r_isRead) begin
          r_rdValid <= 1'b0;
          if (w_reqBusy) begin
            r_err <= 1'b1;
          end else begin
            r_req     <= 1'b1;
            r_we      <= 1'b0;
            r_memAddr <= {w_rxWord[ADDR_W-1:2], 2'b00};
          end
        end
      end

      if (w_wdataDone) begin
        if (w_reqBusy) begin
          r_err <= 1'b1;
        end else begin
          r_req     <= 1'b1;
          r_we      <= 1'b1;
          r_memAddr <= {r_addrLatch[ADDR_W-1:2], 2'b00};
          r_wdata   <= w_rxWord;
        end
      end

      if (w_rdHit) begin
        r_txShift <= mem_rdata_i;
        r_rdValid <= 1'b1;
      end

      // Data that has not arrived by the end of DUMMY is replaced by zeros.
      if (w_dummyDone) begin
        r_sdo     <= w_haveData & w_txWord[31];
        r_txShift <= w_haveData ? {w_txWord[30:0], 1'b0} : 32'h0;
        if (!w_haveData) r_err <= 1'b1;
      end else if (r_state == S_RDATA && w_fall) begin
        r_sdo     <= r_txShift[31];
        r_txShift <= {r_txShift[30:0], 1'b0};
      end
    end
  end

  assign spi_sdo0    = (r_state == S_RDATA) ? r_sdo : 1'b0;
  assign spi_mode    = 2'b00;
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_memAddr;
  assign mem_wdata_o = r_wdata;
  assign mem_be_o    = 4'hF;
  assign err_o       = r_err;

endmodule

// File: tb/tb_spi_slave_mem_bridge.sv
// Testbench for spi_slave_mem_bridge: an SPI master drives directed frames,
// expected memory transactions go into a scoreboard queue, and a bus
// responder/monitor pops and checks them on every granted request.
module tb_spi_slave_mem_bridge;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, cs, sdi;
  logic        sdo;
  logic [1:0]  spiMode;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWdata;
  logic [3:0]  memBe;
  logic        memGnt, memRvalid;
  logic [31:0] memRdata;
  logic        err;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } memTxn_t;

  memTxn_t     expQ[$];
  logic [31:0] memModel [logic [31:0]];
  int          vectors = 0;
  int          miscompares = 0;
  int          errCount = 0;
  int          expErr = 0;
  int          gntDelay = 0;
  logic [31:0] cap;

  spi_slave_mem_bridge dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .spi_sclk     (sclk),
    .spi_cs       (cs),
    .spi_sdi0     (sdi),
    .spi_sdo0     (sdo),
    .spi_mode     (spiMode),
    .mem_req_o    (memReq),
    .mem_we_o     (memWe),
    .mem_addr_o   (memAddr),
    .mem_wdata_o  (memWdata),
    .mem_be_o     (memBe),
    .mem_gnt_i    (memGnt),
    .mem_rvalid_i (memRvalid),
    .mem_rdata_i  (memRdata),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Bus responder and monitor, all on the falling clock edge so it samples
  // away from the DUT's active edge. A grant is raised for one cycle after
  // gntDelay waiting cycles; the request retires on the following rising edge.
  int          waitCnt = 0;
  logic        rdPend = 1'b0;
  logic [31:0] rdAddr = 32'h0;
  logic        holdValid = 1'b0;
  logic        stable = 1'b1;
  logic [31:0] holdAddr, holdData;
  logic        holdWe;

  always @(negedge clk) begin
    if (!rst_n) begin
      memGnt    = 1'b0;
      memRvalid = 1'b0;
      waitCnt   = 0;
      rdPend    = 1'b0;
      holdValid = 1'b0;
    end else begin
      memRvalid = 1'b0;
      if (rdPend) begin
        memRvalid = 1'b1;
        memRdata  = memModel.exists(rdAddr) ? memModel[rdAddr] : 32'h0;
        rdPend    = 1'b0;
      end
      if (err) errCount++;
      if (memGnt) begin
        memGnt = 1'b0;
      end else if (memReq) begin
        if (!holdValid) begin
          holdValid = 1'b1;
          stable    = 1'b1;
          holdAddr  = memAddr;
          holdData  = memWdata;
          holdWe    = memWe;
        end else if (memAddr !== holdAddr || memWdata !== holdData || memWe !== holdWe) begin
          stable = 1'b0;
        end
        if (waitCnt >= gntDelay) begin
          memTxn_t e;
          memGnt    = 1'b1;
          waitCnt   = 0;
          holdValid = 1'b0;
          if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_req: got addr 0x%08h we %0b, expected no request",
                     memAddr, memWe);
          end else begin
            e = expQ.pop_front();
            checkOutput("req_we", {31'h0, memWe}, {31'h0, e.we});
            checkOutput("req_addr", memAddr, e.addr);
            if (e.we) checkOutput("req_wdata", memWdata, e.wdata);
            checkOutput("req_be", {28'h0, memBe}, 32'hF);
            checkOutput("req_stable", {31'h0, stable}, 32'h1);
          end
          if (memWe) memModel[memAddr] = memWdata;
          else begin
            rdPend = 1'b1;
            rdAddr = memAddr;
          end
        end else begin
          waitCnt++;
        end
      end
    end
  end

  // Clock out n bits MSB first (mode 0: change on fall, sample on rise) while
  // capturing SDO on each rise. Optionally time the request after the last rise.
  task automatic sendBits(input logic [79:0] bits, input int n, input bit measureLat,
                          output logic [31:0] c);
    c = 32'h0;
    for (int i = 0; i < n; i++) begin
      sdi = bits[79-i];
      #HALF;
      sclk = 1'b1;
      c = {c[30:0], sdo};
      if (measureLat && i == n - 1) begin
        int lat = 0;
        while (!memReq && lat < 8) begin
          @(negedge clk);
          lat++;
        end
        vectors++;
        if (lat > 4) begin
          miscompares++;
          $display("[TB] FAIL req_latency: got %0d clk, expected at most 4 clk", lat);
        end
      end
      #HALF;
      sclk = 1'b0;
    end
    sdi = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] addr,
                               input logic [31:0] data, input int n,
                               input bit measureLat, output logic [31:0] c);
    @(negedge clk);
    cs = 1'b0;
    sendBits({cmd, addr, data, 8'h00}, n, measureLat, c);
    #HALF;
    cs = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    sclk = 1'b0; cs = 1'b1; sdi = 1'b0; rst_n = 1'b0;
    memGnt = 1'b0; memRvalid = 1'b0; memRdata = 32'h0;
    repeat (5) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_req",  {31'h0, memReq}, 32'h0);
    checkOutput("rst_sdo",  {31'h0, sdo},    32'h0);
    checkOutput("rst_err",  {31'h0, err},    32'h0);
    checkOutput("rst_mode", {30'h0, spiMode}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] write 0x80 = 0x00000FFF");
    expQ.push_back('{we: 1'b1, addr: 32'h80, wdata: 32'h0000_0FFF});
    applyStimulus(8'h02, 32'h80, 32'h0000_0FFF, 72, 1'b1, cap);

    $display("[TB] write with grant delayed 10 clk");
    gntDelay = 10;
    expQ.push_back('{we: 1'b1, addr: 32'h8C, wdata: 32'h0BAD_BEEF});
    applyStimulus(8'h02, 32'h8C, 32'h0BAD_BEEF, 72, 1'b1, cap);
    gntDelay = 0;

    $display("[TB] preload 0x84 and read it back");
    expQ.push_back('{we: 1'b1, addr: 32'h84, wdata: 32'hCAFE_F00D});
    applyStimulus(8'h02, 32'h84, 32'hCAFE_F00D, 72, 1'b1, cap);
    expQ.push_back('{we: 1'b0, addr: 32'h84, wdata: 32'h0});
    applyStimulus(8'h0B, 32'h84, 32'h0, 80, 1'b0, cap);
    checkOutput("read_0x84", cap, 32'hCAFE_F00D);
    checkOutput("err_after_read", errCount, expErr);

    $display("[TB] bad opcode 0x05");
    applyStimulus(8'h05, 32'h80, 32'h1234_5678, 72, 1'b0, cap);
    expErr++;
    checkOutput("err_bad_opcode", errCount, expErr);

    $display("[TB] aborted write then full write to 0x88");
    applyStimulus(8'h02, 32'h88, 32'hDEAD_DEAD, 20, 1'b0, cap);
    expQ.push_back('{we: 1'b1, addr: 32'h88, wdata: 32'h1122_3344});
    applyStimulus(8'h02, 32'h88, 32'h1122_3344, 72, 1'b1, cap);
    expQ.push_back('{we: 1'b0, addr: 32'h88, wdata: 32'h0});
    applyStimulus(8'h0B, 32'h88, 32'h0, 80, 1'b0, cap);
    checkOutput("read_0x88", cap, 32'h1122_3344);
    checkOutput("err_after_abort", errCount, expErr);

    $display("[TB] second write while first still pending");
    gntDelay = 1500;
    expQ.push_back('{we: 1'b1, addr: 32'hA0, wdata: 32'h0000_0055});
    applyStimulus(8'h02, 32'hA0, 32'h0000_0055, 72, 1'b1, cap);
    applyStimulus(8'h02, 32'hA4, 32'h0000_00AA, 72, 1'b0, cap);
    expErr++;
    checkOutput("err_dropped_write", errCount, expErr);
    begin
      int k = 0;
      while (expQ.size() != 0 && k < 3000) begin
        @(negedge clk);
        k++;
      end
    end
    checkOutput("pending_drained", expQ.size(), 0);
    gntDelay = 0;
    repeat (5) @(negedge clk);

    $display("[TB] reset during address phase with a request pending");
    gntDelay = 5000;
    expQ.push_back('{we: 1'b1, addr: 32'h90, wdata: 32'h1234_5678});
    applyStimulus(8'h02, 32'h90, 32'h1234_5678, 72, 1'b1, cap);
    @(negedge clk);
    cs = 1'b0;
    sendBits({8'h02, 32'h94, 32'h0, 8'h00}, 20, 1'b0, cap);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_req",   {31'h0, memReq}, 32'h0);
    checkOutput("rst_mid_addr",  memAddr, 32'h0);
    checkOutput("rst_mid_wdata", memWdata, 32'h0);
    checkOutput("rst_mid_sdo",   {31'h0, sdo}, 32'h0);
    checkOutput("rst_mid_err",   {31'h0, err}, 32'h0);
    repeat (3) @(negedge clk);
    cs = 1'b1;
    expQ.delete();
    gntDelay = 0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    expQ.push_back('{we: 1'b1, addr: 32'h94, wdata: 32'hA5A5_5A5A});
    applyStimulus(8'h02, 32'h94, 32'hA5A5_5A5A, 72, 1'b1, cap);
    expQ.push_back('{we: 1'b0, addr: 32'h94, wdata: 32'h0});
    applyStimulus(8'h0B, 32'h94, 32'h0, 80, 1'b0, cap);
    checkOutput("read_0x94", cap, 32'hA5A5_5A5A);

    checkOutput("err_total", errCount, expErr);
    checkOutput("queue_empty", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
